// File: rtl/vecunit_pkg.sv
// ----------------------------------------------------------------------------
// vecunit_pkg
//   Shared types and constants for the vector unit front end.
//   - NUM_VREGS / NUM_SREGS : architectural vector / scalar register counts
//   - viq_entry_t           : packed decoded instruction carried by the
//                             vector issue queue
//   - VIQ_ENTRY_W           : bit width of viq_entry_t; instantiators use it
//                             as the WIDTH of vec_issue_queue
// ----------------------------------------------------------------------------
package vecunit_pkg;

  localparam int NUM_VREGS  = 32;
  localparam int NUM_SREGS  = 32;
  localparam int VREG_IDX_W = $clog2(NUM_VREGS);
  localparam int SREG_IDX_W = $clog2(NUM_SREGS);
  localparam int NUM_OPS    = 8;

  typedef struct packed {
    logic [NUM_OPS-1:0]    op;       // one-hot operation class
    logic [1:0]            esc;      // element size code
    logic                  masked;
    logic                  strided;
    logic                  is_float;
    logic                  load;
    logic                  iload;
    logic                  store;
    logic                  istore;
    logic [VREG_IDX_W-1:0] src1_v;
    logic [VREG_IDX_W-1:0] src2_v;
    logic [VREG_IDX_W-1:0] dst_v;
    logic [SREG_IDX_W-1:0] src1_s;
    logic [SREG_IDX_W-1:0] src2_s;
    logic [SREG_IDX_W-1:0] dst_s;
  } viq_entry_t;

  localparam int VIQ_ENTRY_W = $bits(viq_entry_t);

endpackage

// File: rtl/viq_storage.sv
// ----------------------------------------------------------------------------
// viq_storage
//   DEPTH x WIDTH register array for the vector issue queue.
//   One synchronous write port, one asynchronous read port, no reset.
// Ports:
//   clk      in   clock, rising edge
//   wr_en    in   write enable
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  mem[rd_addr], combinational
// ----------------------------------------------------------------------------
module viq_storage #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: payload storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/vec_issue_queue.sv
// ----------------------------------------------------------------------------
// vec_issue_queue
//   First-word-fall-through queue of decoded instructions between the vector
//   decoder and the vector control unit, with valid/ready on both sides,
//   synchronous flush, almost-full warning and occupancy count.
// Configuration macro:
//   VIQ_BYPASS_EN - when defined, an instruction arriving at an empty queue
//                   is presented on out_* in the same cycle; if it is
//                   consumed immediately it never touches storage.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   flush               synchronous discard of all entries (wins over push/pop)
//   in_valid/in_data    decoder side; in_ready = ~full & ~flush
//   out_valid/out_data  head entry; out_data is zero when out_valid=0
//   out_ready           control unit consumes the head
//   almost_full         count >= DEPTH-AF_MARGIN
//   count               occupancy 0..DEPTH
// ----------------------------------------------------------------------------
module vec_issue_queue
  import vecunit_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH - AF_MARGIN);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             full, empty;
  logic             bypass, bypass_thru;
  logic             push, pop, do_push, do_pop;
  logic [WIDTH-1:0] rd_data;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == {CW{1'b0}});

`ifdef VIQ_BYPASS_EN
  assign bypass = empty & in_valid & ~flush & rst_n;
`else
  assign bypass = 1'b0;
`endif
  // A bypassed instruction that is consumed at once leaves no trace in state.
  assign bypass_thru = bypass & out_ready;

  // rst_n gating keeps in_ready low for the whole reset, not just after it.
  assign in_ready    = rst_n & ~full & ~flush;
  assign out_valid   = ~empty | bypass;
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign do_push     = push & ~bypass_thru;
  assign do_pop      = pop & ~bypass_thru;
  assign almost_full = (count_q >= AF_LEVEL);
  assign count       = count_q;

  viq_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_storage (
    .clk     (clk),
    .wr_en   (do_push),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  // Head presentation: stored head first, bypassed input when empty, else zero.
  always_comb begin
    out_data = {WIDTH{1'b0}};
    if (!empty) begin
      out_data = rd_data;
    end else if (bypass) begin
      out_data = in_data;
    end else begin
      out_data = {WIDTH{1'b0}};
    end
  end

  // Pointer and occupancy next-state; flush overrides any handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_vec_issue_queue.sv
// ----------------------------------------------------------------------------
// tb_vec_issue_queue
//   Directed self-checking bench for vec_issue_queue (WIDTH=64, DEPTH=16,
//   AF_MARGIN=2). Inputs change 1ns after the rising edge; outputs are
//   checked a further 1ns later, well away from the next edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vec_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;
  logic        almost_full;
  logic [4:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  vec_issue_queue #(.WIDTH(64), .DEPTH(16), .AF_MARGIN(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .almost_full (almost_full),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int next_in;
    int next_exp;
    int budget;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b0;

    // Reset state
    #13;
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_count", {59'd0, count}, 64'd0);
    check_eq("rst_out_data", out_data, 64'd0);
    rst_n = 1'b1;
    step();
    #1;
    check_eq("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("post_rst_af", {63'd0, almost_full}, 64'd0);

    // Fill with out_ready=0; almost_full from count 14
    for (int i = 0; i < 16; i++) begin
      push_one(64'd100 + 64'(i));
      #1;
      check_eq("fill_count", {59'd0, count}, 64'(i + 1));
      check_eq("fill_af", {63'd0, almost_full}, (i + 1 >= 14) ? 64'd1 : 64'd0);
    end
    check_eq("full_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("full_head", out_data, 64'd100);

    // 17th push is held and not accepted
    in_valid = 1'b1; in_data = 64'd999;
    step(); step();
    #1;
    check_eq("held_count", {59'd0, count}, 64'd16);
    check_eq("held_in_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;

    // Drain in order
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check_eq("drain_data", out_data, 64'd100 + 64'(i));
      step();
    end
    out_ready = 1'b0;
    #1;
    check_eq("drained_count", {59'd0, count}, 64'd0);
    check_eq("drained_valid", {63'd0, out_valid}, 64'd0);
    check_eq("drained_data", out_data, 64'd0);

    // Order/wrap: stream 0..39 with pseudo-random consumer stalls
    next_in = 0; next_exp = 0; budget = 0;
    while (next_exp < 40 && budget < 1000) begin
      in_valid  = (next_in < 40);
      in_data   = 64'(next_in);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        check_eq("order_data", out_data, 64'(next_exp));
        next_exp++;
      end
      if (in_valid && in_ready) next_in++;
      step();
      budget++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("order_all_popped", 64'(next_exp), 64'd40);
    #1;
    check_eq("order_count", {59'd0, count}, 64'd0);

    // Simultaneous push and pop at count 5
    for (int i = 0; i < 5; i++) push_one(64'd200 + 64'(i));
    #1;
    check_eq("simul_pre_count", {59'd0, count}, 64'd5);
    check_eq("simul_pre_head", out_data, 64'd200);
    in_valid = 1'b1; in_data = 64'd205; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check_eq("simul_count", {59'd0, count}, 64'd5);
    check_eq("simul_head", out_data, 64'd201);

    // Flush at count 9 with in_valid high
    for (int i = 0; i < 4; i++) push_one(64'd206 + 64'(i));
    #1;
    check_eq("flush_pre_count", {59'd0, count}, 64'd9);
    flush = 1'b1; in_valid = 1'b1; in_data = 64'hDEAD;
    #1;
    check_eq("flush_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("flush_cycle_valid", {63'd0, out_valid}, 64'd1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("flush_count", {59'd0, count}, 64'd0);
    check_eq("flush_valid", {63'd0, out_valid}, 64'd0);
    check_eq("flush_data", out_data, 64'd0);
    push_one(64'h77);
    #1;
    check_eq("post_flush_count", {59'd0, count}, 64'd1);
    check_eq("post_flush_head", out_data, 64'h77);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Bypass / minimum latency from empty
    in_valid = 1'b1; in_data = 64'hA5; out_ready = 1'b1;
    #1;
`ifdef VIQ_BYPASS_EN
    check_eq("byp_same_valid", {63'd0, out_valid}, 64'd1);
    check_eq("byp_same_data", out_data, 64'hA5);
    step();
    in_valid = 1'b0;
    #1;
    check_eq("byp_count", {59'd0, count}, 64'd0);
    check_eq("byp_after_valid", {63'd0, out_valid}, 64'd0);
`else
    check_eq("nobyp_same_valid", {63'd0, out_valid}, 64'd0);
    check_eq("nobyp_same_data", out_data, 64'd0);
    step();
    in_valid = 1'b0;
    #1;
    check_eq("nobyp_next_valid", {63'd0, out_valid}, 64'd1);
    check_eq("nobyp_next_data", out_data, 64'hA5);
    check_eq("nobyp_count", {59'd0, count}, 64'd1);
    step();
    #1;
    check_eq("nobyp_popped_count", {59'd0, count}, 64'd0);
`endif
    out_ready = 1'b0;

    // Mid-operation async reset
    for (int i = 0; i < 3; i++) push_one(64'd300 + 64'(i));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_count", {59'd0, count}, 64'd0);
    check_eq("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("mid_rst_data", out_data, 64'd0);
    rst_n = 1'b1;
    step();
    check_eq("mid_rst_release_ready", {63'd0, in_ready}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
